// File: rtl/bft_pkg.sv
// Shared definitions for the BFT leaf shim array: packet width defaults, retry counter width,
// output-select encoding and a constant clog2 helper.
package bft_pkg;

    localparam int P_SZ_DEF    = 49;
    localparam int VALID_BIT   = P_SZ_DEF - 1;
    localparam int RETRY_CNT_W = 16;

    // Source of the next packet shown to the network on a leaf
    typedef enum logic [1:0] {
        SEL_IDLE   = 2'd0,
        SEL_FIFO   = 2'd1,
        SEL_RESEND = 2'd2
    } out_sel_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bft_leaf_shim.sv
// One leaf of the BFT shim: ingress FIFO, out_reg/inflight retransmit pair and, when
// BFT_RETRY_CNT_EN is defined, a saturating count of honoured resends.
module bft_leaf_shim
    import bft_pkg::*;
#(
    parameter int P_SZ       = P_SZ_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pe_valid,
    input  logic [P_SZ-2:0]   pe_data,
    output logic              pe_ready,
    output logic [P_SZ-1:0]   net_dout,
    input  logic              net_resend
`ifdef BFT_RETRY_CNT_EN
    ,
    output logic [RETRY_CNT_W-1:0] resend_cnt
`endif
);

    localparam int PTR_W = clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [P_SZ-1:0]  mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [P_SZ-1:0]  out_reg_r;
    logic [P_SZ-1:0]  inflight_r;

    logic             ready_s;
    logic             push_s;
    logic             pop_s;
    out_sel_e         sel_s;
    logic [P_SZ-1:0]  out_nxt_s;

    // Ready is held low while reset is asserted so nothing is accepted into a clearing FIFO
    assign ready_s  = !reset && (count_r != CNT_FULL);
    assign push_s   = pe_valid && ready_s;
    assign pe_ready = ready_s;
    assign net_dout = out_reg_r;

    // Choose retransmit, FIFO head or bubble for the next shown packet
    always_comb begin
        sel_s     = SEL_IDLE;
        pop_s     = 1'b0;
        out_nxt_s = {P_SZ{1'b0}};
        if (net_resend && inflight_r[P_SZ-1]) begin
            sel_s = SEL_RESEND;
        end else if (count_r != {CNT_W{1'b0}}) begin
            sel_s = SEL_FIFO;
        end else begin
            sel_s = SEL_IDLE;
        end
        case (sel_s)
            SEL_RESEND: out_nxt_s = inflight_r;
            SEL_FIFO: begin
                out_nxt_s = mem_r[rd_ptr_r];
                pop_s     = 1'b1;
            end
            SEL_IDLE:   out_nxt_s = {P_SZ{1'b0}};
            default:    out_nxt_s = {P_SZ{1'b0}};
        endcase
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {1'b1, pe_data};
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // A resend swaps out_reg and inflight, so every shown packet is judged exactly one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            out_reg_r  <= {P_SZ{1'b0}};
            inflight_r <= {P_SZ{1'b0}};
        end else begin
            out_reg_r  <= out_nxt_s;
            inflight_r <= out_reg_r;
        end
    end

`ifdef BFT_RETRY_CNT_EN
    logic [RETRY_CNT_W-1:0] resend_cnt_r;

    // Saturating count of honoured resends
    always_ff @(posedge clk) begin
        if (reset) begin
            resend_cnt_r <= {RETRY_CNT_W{1'b0}};
        end else if ((sel_s == SEL_RESEND) && (resend_cnt_r != {RETRY_CNT_W{1'b1}})) begin
            resend_cnt_r <= resend_cnt_r + {{(RETRY_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            resend_cnt_r <= resend_cnt_r;
        end
    end

    assign resend_cnt = resend_cnt_r;
`endif

endmodule

// File: rtl/bft_leaf_shim_array.sv
// NUM_LEAVES-wide shim between PE ports and the BFT network, with registered egress.
// Optional per-leaf resend counters are enabled by defining BFT_RETRY_CNT_EN.
module bft_leaf_shim_array
    import bft_pkg::*;
#(
    parameter int NUM_LEAVES = 32,
    parameter int P_SZ       = P_SZ_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_LEAVES-1:0]          pe_valid,
    input  logic [NUM_LEAVES*(P_SZ-1)-1:0] pe_data,
    output logic [NUM_LEAVES-1:0]          pe_ready,
    output logic [NUM_LEAVES*P_SZ-1:0]     net_dout,
    input  logic [NUM_LEAVES-1:0]          net_resend,
    input  logic [NUM_LEAVES*P_SZ-1:0]     net_din,
    output logic [NUM_LEAVES*P_SZ-1:0]     pe_din
`ifdef BFT_RETRY_CNT_EN
    ,
    output logic [NUM_LEAVES*RETRY_CNT_W-1:0] resend_cnt
`endif
);

    logic [NUM_LEAVES*P_SZ-1:0] pe_din_r;

    for (genvar i = 0; i < NUM_LEAVES; i++) begin : g_leaf
        bft_leaf_shim #(
            .P_SZ       (P_SZ),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_leaf (
            .clk        (clk),
            .reset      (reset),
            .pe_valid   (pe_valid[i]),
            .pe_data    (pe_data[i*(P_SZ-1) +: (P_SZ-1)]),
            .pe_ready   (pe_ready[i]),
            .net_dout   (net_dout[i*P_SZ +: P_SZ]),
            .net_resend (net_resend[i])
`ifdef BFT_RETRY_CNT_EN
            ,
            .resend_cnt (resend_cnt[i*RETRY_CNT_W +: RETRY_CNT_W])
`endif
        );
    end

    // Network-to-PE path: one register stage, no backpressure
    always_ff @(posedge clk) begin
        if (reset) begin
            pe_din_r <= {(NUM_LEAVES*P_SZ){1'b0}};
        end else begin
            pe_din_r <= net_din;
        end
    end

    assign pe_din = pe_din_r;

endmodule

// File: tb/tb_bft_leaf_shim_array.sv
// Directed self-checking bench for bft_leaf_shim_array (default parameters).
module tb_bft_leaf_shim_array;

    localparam int NL = 32;
    localparam int PS = 49;
    localparam int DW = PS - 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NL-1:0]        pe_valid;
    logic [NL*DW-1:0]     pe_data;
    logic [NL-1:0]        pe_ready;
    logic [NL*PS-1:0]     net_dout;
    logic [NL-1:0]        net_resend;
    logic [NL*PS-1:0]     net_din;
    logic [NL*PS-1:0]     pe_din;
`ifdef BFT_RETRY_CNT_EN
    logic [NL*16-1:0]     resend_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bft_leaf_shim_array #(.NUM_LEAVES(NL), .P_SZ(PS), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .pe_valid   (pe_valid),
        .pe_data    (pe_data),
        .pe_ready   (pe_ready),
        .net_dout   (net_dout),
        .net_resend (net_resend),
        .net_din    (net_din),
        .pe_din     (pe_din)
`ifdef BFT_RETRY_CNT_EN
        ,
        .resend_cnt (resend_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PS-1:0] dout_of(input int i);
        return net_dout[i*PS +: PS];
    endfunction

    function automatic logic [PS-1:0] pkt(input logic [DW-1:0] d);
        return {1'b1, d};
    endfunction

    task automatic set_leaf(input int i, input logic v, input logic [DW-1:0] d);
        pe_valid[i]        = v;
        pe_data[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        pe_valid   = {NL{1'b1}};
        pe_data    = {(NL*DW){1'b1}};
        net_resend = {NL{1'b0}};
        net_din    = {(NL*PS){1'b1}};
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (net_dout !== {(NL*PS){1'b0}}) begin errors++; $display("FAIL reset_net_dout cyc %0d: got %h expected 0", c, net_dout); end
            checks++;
            if (pe_din !== {(NL*PS){1'b0}}) begin errors++; $display("FAIL reset_pe_din cyc %0d: got %h expected 0", c, pe_din); end
            checks++;
            if (pe_ready !== {NL{1'b0}}) begin errors++; $display("FAIL reset_pe_ready cyc %0d: got %h expected 0", c, pe_ready); end
        end
        reset    = 1'b0;
        pe_valid = {NL{1'b0}};
        pe_data  = {(NL*DW){1'b0}};
        net_din  = {(NL*PS){1'b0}};
        tick();
        checks++;
        if (pe_ready !== {NL{1'b1}}) begin errors++; $display("FAIL ready_after_reset: got %h expected ffffffff", pe_ready); end
        checks++;
        if (net_dout !== {(NL*PS){1'b0}}) begin errors++; $display("FAIL dout_after_reset: got %h expected 0", net_dout); end
    endtask

    task automatic test_single_latency();
        set_leaf(5, 1'b1, 48'hABC);
        tick();
        set_leaf(5, 1'b0, 48'h0);
        checks++;
        if (dout_of(5) !== {PS{1'b0}}) begin errors++; $display("FAIL lat_n1: got %h expected 0", dout_of(5)); end
        tick();
        checks++;
        if (dout_of(5) !== pkt(48'hABC)) begin errors++; $display("FAIL lat_n2: got %h expected %h", dout_of(5), pkt(48'hABC)); end
        checks++;
        if ((dout_of(4) | dout_of(6)) !== {PS{1'b0}}) begin errors++; $display("FAIL lat_neighbours: got %h expected 0", dout_of(4) | dout_of(6)); end
        tick();
        checks++;
        if (dout_of(5) !== {PS{1'b0}}) begin errors++; $display("FAIL lat_n3: got %h expected 0", dout_of(5)); end
    endtask

    task automatic test_resend_swap();
        logic [PS-1:0] exp_seq [5];
        exp_seq[0] = pkt(48'hA);
        exp_seq[1] = pkt(48'hB);
        exp_seq[2] = pkt(48'hC);
        exp_seq[3] = pkt(48'hB);
        exp_seq[4] = {PS{1'b0}};
        set_leaf(0, 1'b1, 48'hA);
        tick();
        set_leaf(0, 1'b1, 48'hB);
        tick();
        checks++;
        if (dout_of(0) !== exp_seq[0]) begin errors++; $display("FAIL swap_seq0: got %h expected %h", dout_of(0), exp_seq[0]); end
        set_leaf(0, 1'b1, 48'hC);
        tick();
        set_leaf(0, 1'b0, 48'h0);
        for (int k = 1; k < 5; k++) begin
            checks++;
            if (dout_of(0) !== exp_seq[k]) begin errors++; $display("FAIL swap_seq%0d: got %h expected %h", k, dout_of(0), exp_seq[k]); end
            net_resend[0] = (k == 2);
            tick();
        end
        net_resend[0] = 1'b0;
        checks++;
        if (dout_of(0) !== {PS{1'b0}}) begin errors++; $display("FAIL swap_tail: got %h expected 0", dout_of(0)); end
    endtask

    task automatic test_full_resend();
        int acc;
        logic [PS-1:0] p [6];
        for (int k = 0; k < 6; k++) p[k] = pkt(48'h300 + DW'(k));
        acc = 0;
        net_resend[3] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (pe_ready[3]) begin
                set_leaf(3, 1'b1, p[acc][DW-1:0]);
                acc++;
            end else begin
                set_leaf(3, 1'b0, 48'h0);
            end
            tick();
        end
        set_leaf(3, 1'b0, 48'h0);
        checks++;
        if (acc !== 6) begin errors++; $display("FAIL full_accepted: got %0d expected 6", acc); end
        checks++;
        if (pe_ready[3] !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", pe_ready[3]); end
        checks++;
        if (dout_of(3) !== p[0]) begin errors++; $display("FAIL alt0: got %h expected %h", dout_of(3), p[0]); end
        tick();
        checks++;
        if (dout_of(3) !== p[1]) begin errors++; $display("FAIL alt1: got %h expected %h", dout_of(3), p[1]); end
        tick();
        checks++;
        if (dout_of(3) !== p[0]) begin errors++; $display("FAIL alt2: got %h expected %h", dout_of(3), p[0]); end
        checks++;
        if (pe_ready[3] !== 1'b0) begin errors++; $display("FAIL alt_ready: got %b expected 0", pe_ready[3]); end
        net_resend[3] = 1'b0;
        tick();
        checks++;
        if (pe_ready[3] !== 1'b1) begin errors++; $display("FAIL drain_ready: got %b expected 1", pe_ready[3]); end
        for (int k = 2; k < 6; k++) begin
            checks++;
            if (dout_of(3) !== p[k]) begin errors++; $display("FAIL drain%0d: got %h expected %h", k, dout_of(3), p[k]); end
            tick();
        end
        checks++;
        if (dout_of(3) !== {PS{1'b0}}) begin errors++; $display("FAIL drain_end: got %h expected 0", dout_of(3)); end
    endtask

    task automatic test_egress();
        logic [PS-1:0] v;
        v = 49'h1_0000_0000_0123;
        net_din[31*PS +: PS] = v;
        checks++;
        if (pe_din !== {(NL*PS){1'b0}}) begin errors++; $display("FAIL egress_pre: got %h expected 0", pe_din); end
        tick();
        net_din = {(NL*PS){1'b0}};
        checks++;
        if (pe_din[31*PS +: PS] !== v) begin errors++; $display("FAIL egress_leaf31: got %h expected %h", pe_din[31*PS +: PS], v); end
        checks++;
        if (pe_din[31*PS-1:0] !== {(31*PS){1'b0}}) begin errors++; $display("FAIL egress_others: got %h expected 0", pe_din[31*PS-1:0]); end
        tick();
        checks++;
        if (pe_din !== {(NL*PS){1'b0}}) begin errors++; $display("FAIL egress_post: got %h expected 0", pe_din); end
    endtask

    task automatic test_reset_mid_traffic();
        set_leaf(7, 1'b1, 48'h71);
        tick();
        set_leaf(7, 1'b1, 48'h72);
        tick();
        set_leaf(7, 1'b0, 48'h0);
        checks++;
        if (dout_of(7) !== pkt(48'h71)) begin errors++; $display("FAIL mid_pre: got %h expected %h", dout_of(7), pkt(48'h71)); end
        reset = 1'b1;
        tick();
        checks++;
        if (net_dout !== {(NL*PS){1'b0}}) begin errors++; $display("FAIL mid_reset_dout: got %h expected 0", net_dout); end
        checks++;
        if (pe_ready !== {NL{1'b0}}) begin errors++; $display("FAIL mid_reset_ready: got %h expected 0", pe_ready); end
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (dout_of(7) !== {PS{1'b0}}) begin errors++; $display("FAIL mid_after%0d: got %h expected 0", c, dout_of(7)); end
        end
    endtask

`ifdef BFT_RETRY_CNT_EN
    task automatic test_retry_cnt();
        checks++;
        if (resend_cnt[16 +: 16] !== 16'h0000) begin errors++; $display("FAIL cnt_init: got %h expected 0000", resend_cnt[16 +: 16]); end
        set_leaf(1, 1'b1, 48'h11);
        tick();
        set_leaf(1, 1'b1, 48'h12);
        tick();
        set_leaf(1, 1'b0, 48'h0);
        tick();
        net_resend[1] = 1'b1;
        repeat (5) tick();
        checks++;
        if (resend_cnt[16 +: 16] !== 16'd5) begin errors++; $display("FAIL cnt_five: got %h expected 0005", resend_cnt[16 +: 16]); end
        net_resend[1] = 1'b0;
        repeat (3) tick();
        net_resend[1] = 1'b1;
        repeat (3) tick();
        checks++;
        if (resend_cnt[16 +: 16] !== 16'd5) begin errors++; $display("FAIL cnt_ignored: got %h expected 0005", resend_cnt[16 +: 16]); end
        net_resend[1] = 1'b0;
        set_leaf(1, 1'b1, 48'h13);
        tick();
        set_leaf(1, 1'b1, 48'h14);
        tick();
        set_leaf(1, 1'b0, 48'h0);
        tick();
        net_resend[1] = 1'b1;
        repeat (70000) tick();
        checks++;
        if (resend_cnt[16 +: 16] !== 16'hFFFF) begin errors++; $display("FAIL cnt_sat: got %h expected ffff", resend_cnt[16 +: 16]); end
        net_resend[1] = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (resend_cnt[16 +: 16] !== 16'h0000) begin errors++; $display("FAIL cnt_reset: got %h expected 0000", resend_cnt[16 +: 16]); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_latency();
        test_resend_swap();
        test_full_resend();
        test_egress();
        test_reset_mid_traffic();
`ifdef BFT_RETRY_CNT_EN
        test_retry_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
